muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits beside the ALU in the EX stage of the 5-stage pipeline.
- Accepts one M-extension operation at a time from ID/EX, computes it over multiple cycles, and returns the result with its destination register tag.
- Holds the pipeline with a stall signal that the hazard-detection logic ORs into PC/IF_ID/ID_EX write-enables.
- Generalised to any XLEN; supports all eight RV32M funct3 modes.

Parameters:
XLEN, 32, operand/result width in bits (even, >= 8)
CW, $clog2(XLEN+1), iteration counter width (derived, not overridden)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
valid_i  input  1  EX holds an M-extension op (opcode 0110011, funct7 0000001)
op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_i  input  XLEN  forwarded operand A
rs2_i  input  XLEN  forwarded operand B
rd_i  input  5  destination register
flush_i  input  1  abort current op (branch/exception squash)
ready_o  output  1  unit idle, can accept
stall_o  output  1  freeze IF/ID/EX until result produced
valid_o  output  1  result_o/rd_o valid, one-cycle pulse
result_o  output  XLEN  result
rd_o  output  5  destination of result

Behaviour:
- States: IDLE, CALC, DONE (registered); 2-bit encoding.
- Reset (rst_i low, async): state IDLE, counter 0, internal accumulators 0, result_o 0, rd_o 0, valid_o 0.
- ready_o = (state==IDLE). stall_o = (IDLE & valid_i) | CALC (combinational); low in DONE.
- Accept: at an edge with IDLE & valid_i & !flush_i. Latch op, rd, sign flags, operand magnitudes; load counter with XLEN; go to CALC.
- Special divides at accept go to DONE directly (1-cycle latency):
  - rs2==0: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM, rs1 = most-negative, rs2 = -1): DIV gives rs1, REM gives 0.
- Signedness: signed operands take magnitude when negative.
  - MULH: both signed. MULHSU: rs1 signed only. MUL/MULHU/DIVU/REMU: both unsigned.
- MUL*: radix-2 shift-add into a 2*XLEN product, one bit per CALC cycle.
  - Product negated if the sign flags differ.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DIV*: restoring division, one quotient bit per CALC cycle.
  - Quotient negated if the sign flags differ.
  - Remainder takes the sign of rs1.
- CALC: one iteration per edge, counter decrements. At the edge where counter==1, apply the sign fix-up, register result_o/rd_o, and go to DONE.
- Latency: valid_o goes high exactly XLEN cycles after the accept edge (1 cycle for special divides).
- DONE: valid_o=1 for one cycle; stall_o=0 so the pipeline advances. The same instruction is not re-accepted (ready_o=0). Next edge goes to IDLE.
- Back-to-back M ops: the second is accepted on the first IDLE cycle; there is no bubble beyond DONE.
- result_o/rd_o hold their last value until the next DONE; consumers qualify with valid_o.
- flush_i (sync) has priority over everything:
  - In any state, the next edge goes to IDLE and valid_o stays 0.
  - In IDLE with valid_i, flush_i blocks acceptance.
  - In DONE, flush_i suppresses nothing already presented but forces IDLE.
- valid_i deasserting during CALC is ignored; the op completes.
- Async reset mid-CALC aborts immediately; the unit is idle on the first edge after release.
- All arithmetic is width-exact to XLEN/2*XLEN; no X propagation from unused operand bits.

Test Plan:
1. MUL rs1=7, rs2=0xFFFFFFFD -> result_o 0xFFFFFFEB, valid_o exactly 32 cycles after accept, stall_o high through CALC.
2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
4. DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with valid_o 1 cycle after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
5. flush_i pulsed at CALC cycle 10 -> no valid_o, ready_o high next cycle, new op accepted and correct. Back-to-back MUL then DIV -> two valid_o pulses, rd_o tags match.
6. rst_i low mid-CALC -> outputs 0 immediately. Rerun scenarios 1 and 3 with XLEN=16, checking 16-cycle latency and scaled results.

Source files
------------

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. It takes one
//   M-extension op at a time and produces one result bit per cycle. A radix-2
//   shift-add multiplier and a restoring divider share one 2*XLEN accumulator.
//   Divide-by-zero and signed overflow finish in the cycle after accept.
//
// Ports
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-low reset
//   valid_i  : an M op is present in EX
//   op_i     : funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   rs1_i    : operand A
//   rs2_i    : operand B
//   rd_i     : destination register tag
//   flush_i  : squash whatever is in flight, return to idle
//   ready_o  : unit idle
//   stall_o  : hold IF/ID/EX while an op is being accepted or computed
//   valid_o  : one-cycle pulse, result_o/rd_o valid
//   result_o : result (holds its value until the next completion)
//   rd_o     : destination tag of result_o
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_op;
    logic [4:0]            r_rd;
    logic                  r_neg_a;
    logic                  r_neg_b;
    logic [2*XLEN-1:0]     r_acc;   // mul: {partial sum, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]       r_b;     // multiplicand / divisor magnitude

    // ---------------- accept-side decode ----------------
    logic            w_accept;
    logic            w_sa;
    logic            w_sb;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div0;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept = (r_state == S_IDLE) && valid_i && !flush_i;
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    assign w_sa     = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    assign w_sb     = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    assign w_neg_a  = w_sa && rs1_i[XLEN-1];
    assign w_neg_b  = w_sb && rs2_i[XLEN-1];
    // The most-negative value maps onto itself, which is also its unsigned magnitude.
    assign w_mag_a  = w_neg_a ? -rs1_i : rs1_i;
    assign w_mag_b  = w_neg_b ? -rs2_i : rs2_i;

    assign w_div0    = op_i[2] && (rs2_i == '0);
    assign w_ovf     = op_i[2] && !op_i[0] && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_i);
    assign w_special = w_div0 || w_ovf;
    // op_i[1] distinguishes REM/REMU from DIV/DIVU
    assign w_special_res = w_div0 ? (op_i[1] ? rs1_i : '1)
                                  : (op_i[1] ? '0 : rs1_i);

    // ---------------- one iteration ----------------
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_trial;
    logic              w_ge;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_rem_next;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_calc_res;

    assign w_hi  = r_acc[2*XLEN-1:XLEN];
    assign w_lo  = r_acc[XLEN-1:0];

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_sum      = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_sum, w_lo[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits.
    assign w_trial    = {w_hi, w_lo[XLEN-1]};
    assign w_ge       = (w_trial >= {1'b0, r_b});
    assign w_diff     = w_trial[XLEN-1:0] - r_b;
    assign w_rem_next = w_ge ? w_diff : w_trial[XLEN-1:0];
    assign w_div_next = {w_rem_next, w_lo[XLEN-2:0], w_ge};

    // Sign fix-up applied on the final iteration
    assign w_prod = (r_neg_a ^ r_neg_b) ? -w_mul_next : w_mul_next;
    assign w_quo  = (r_neg_a ^ r_neg_b) ? -w_div_next[XLEN-1:0] : w_div_next[XLEN-1:0];
    assign w_rem  = r_neg_a ? -w_div_next[2*XLEN-1:XLEN] : w_div_next[2*XLEN-1:XLEN];

    always_comb begin
        w_calc_res = w_prod[2*XLEN-1:XLEN];
        if (r_op[2]) begin
            w_calc_res = r_op[1] ? w_rem : w_quo;
        end else if (r_op[1:0] == 2'b00) begin
            w_calc_res = w_prod[XLEN-1:0];
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (flush_i) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_next = w_special ? S_DONE : S_CALC;
                S_CALC: if (r_cnt == CW'(1)) w_state_next = S_DONE;
                S_DONE: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ready_o = (r_state == S_IDLE);
        stall_o = ((r_state == S_IDLE) && valid_i) || (r_state == S_CALC);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_rd     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_acc    <= '0;
            r_b      <= '0;
            result_o <= '0;
            rd_o     <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (w_accept) begin
                r_op    <= op_i;
                r_rd    <= rd_i;
                r_neg_a <= w_neg_a;
                r_neg_b <= w_neg_b;
                r_acc   <= {{XLEN{1'b0}}, w_mag_a};
                r_b     <= w_mag_b;
                r_cnt   <= CW'(XLEN);
                if (w_special) begin
                    result_o <= w_special_res;
                    rd_o     <= rd_i;
                    valid_o  <= 1'b1;
                end
            end else if ((r_state == S_CALC) && !flush_i) begin
                r_acc <= r_op[2] ? w_div_next : w_mul_next;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    result_o <= w_calc_res;
                    rd_o     <= r_rd;
                    valid_o  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed, table-driven bench for muldiv_unit. A 32-bit and a 16-bit
//   instance share clock and reset; each vector targets one of them.
//   Latency is counted as rising edges after the accept edge until valid_o
//   is seen (XLEN for iterative ops, 0 for divides resolved at accept).
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // 32-bit unit
    logic        v32, f32;
    logic [2:0]  op32;
    logic [31:0] a32, b32;
    logic [4:0]  rd32;
    logic        rdy32, stl32, vo32;
    logic [31:0] res32;
    logic [4:0]  rdo32;
    // 16-bit unit
    logic        v16, f16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic [4:0]  rd16;
    logic        rdy16, stl16, vo16;
    logic [15:0] res16;
    logic [4:0]  rdo16;

    muldiv_unit #(.XLEN(32)) u32 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(v32), .op_i(op32),
        .rs1_i(a32), .rs2_i(b32), .rd_i(rd32), .flush_i(f32),
        .ready_o(rdy32), .stall_o(stl32), .valid_o(vo32),
        .result_o(res32), .rd_o(rdo32)
    );

    muldiv_unit #(.XLEN(16)) u16 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(v16), .op_i(op16),
        .rs1_i(a16), .rs2_i(b16), .rd_i(rd16), .flush_i(f16),
        .ready_o(rdy16), .stall_o(stl16), .valid_o(vo16),
        .result_o(res16), .rd_o(rdo16)
    );

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    typedef struct {
        bit          w16;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w16, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        if (w16) begin
            v16 = v; op16 = op; a16 = a[15:0]; b16 = b[15:0]; rd16 = rd;
        end else begin
            v32 = v; op32 = op; a32 = a; b32 = b; rd32 = rd;
        end
    endtask

    function automatic logic cur_valid(input bit w16);
        return w16 ? vo16 : vo32;
    endfunction
    function automatic logic cur_stall(input bit w16);
        return w16 ? stl16 : stl32;
    endfunction
    function automatic logic cur_ready(input bit w16);
        return w16 ? rdy16 : rdy32;
    endfunction
    function automatic logic [31:0] cur_res(input bit w16);
        return w16 ? {16'h0, res16} : res32;
    endfunction
    function automatic logic [4:0] cur_rd(input bit w16);
        return w16 ? rdo16 : rdo32;
    endfunction

    // Called at the negedge following the accept edge. Returns the number of
    // edges after the accept edge at which valid_o was first seen.
    task automatic wait_valid(input bit w16, output int k, output bit seen, output int stall_low);
        k = 0; seen = 1'b0; stall_low = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (cur_valid(w16)) begin
                seen = 1'b1;
            end else begin
                if (!cur_stall(w16)) stall_low++;
                k++;
                @(negedge clk);
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: valid_o never rose within 100 cycles");
        end
    endtask

    task automatic run_op(input string nm, input vec_t v);
        int  k;
        bit  seen;
        int  stall_low;
        @(negedge clk);
        drive(v.w16, 1'b1, v.op, v.a, v.b, v.rd);
        @(posedge clk);
        @(negedge clk);
        drive(v.w16, 1'b0, v.op, v.a, v.b, v.rd);
        wait_valid(v.w16, k, seen, stall_low);
        if (seen) begin
            chk({nm, ".result"}, cur_res(v.w16), v.exp);
            chk({nm, ".rd"}, {27'h0, cur_rd(v.w16)}, {27'h0, v.rd});
            chk({nm, ".latency"}, k, v.lat);
            if (v.lat > 0) chk({nm, ".stall_in_calc"}, stall_low, 0);
            chk({nm, ".done_stall"}, {31'h0, cur_stall(v.w16)}, 32'h0);
            chk({nm, ".done_ready"}, {31'h0, cur_ready(v.w16)}, 32'h0);
            @(negedge clk);
            chk({nm, ".pulse_end"}, {31'h0, cur_valid(v.w16)}, 32'h0);
            chk({nm, ".idle_again"}, {31'h0, cur_ready(v.w16)}, 32'h1);
            chk({nm, ".hold"}, cur_res(v.w16), v.exp);
        end
        $display("[TB] %s op=%0d a=%h b=%h -> %h (exp %h) lat=%0d", nm, v.op, v.a, v.b,
                 cur_res(v.w16), v.exp, k);
    endtask

    initial begin
        int  k;
        bit  seen;
        int  stall_low;
        int  pulses;

        vecs[0]  = '{0, MUL,    32'h00000007, 32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 32};
        vecs[1]  = '{0, MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 32};
        vecs[2]  = '{0, MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 32};
        vecs[3]  = '{0, MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd4,  32'hFFFFFFFF, 32};
        vecs[4]  = '{0, DIV,    32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFD, 32};
        vecs[5]  = '{0, REM,    32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF, 32};
        vecs[6]  = '{0, DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       32};
        vecs[7]  = '{0, REMU,   32'd100,      32'd7,        5'd8,  32'd2,        32};
        vecs[8]  = '{0, DIVU,   32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 0};
        vecs[9]  = '{0, REM,    32'd5,        32'd0,        5'd10, 32'd5,        0};
        vecs[10] = '{0, DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 0};
        vecs[11] = '{0, REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 0};
        vecs[12] = '{0, MUL,    32'h12345678, 32'h00000010, 5'd13, 32'h23456780, 32};
        vecs[13] = '{0, MULH,   32'h80000000, 32'h80000000, 5'd14, 32'h40000000, 32};
        vecs[14] = '{0, MULHSU, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 32};
        vecs[15] = '{0, DIV,    32'd100,      32'hFFFFFFF9, 5'd16, 32'hFFFFFFF2, 32};
        vecs[16] = '{0, REM,    32'hFFFFFF9C, 32'd7,        5'd17, 32'hFFFFFFFE, 32};
        vecs[17] = '{0, DIV,    32'h80000000, 32'h00000001, 5'd18, 32'h80000000, 32};
        vecs[18] = '{0, REMU,   32'hFFFFFFFF, 32'h00000010, 5'd19, 32'h0000000F, 32};
        vecs[19] = '{0, REM,    32'h80000000, 32'h00000000, 5'd20, 32'h80000000, 0};
        vecs[20] = '{1, MUL,    32'h0007,     32'hFFFD,     5'd21, 32'h0000FFEB, 16};
        vecs[21] = '{1, DIV,    32'hFFF9,     32'h0002,     5'd22, 32'h0000FFFD, 16};
        vecs[22] = '{1, REM,    32'hFFF9,     32'h0002,     5'd23, 32'h0000FFFF, 16};
        vecs[23] = '{1, DIVU,   32'd100,      32'd7,        5'd24, 32'd14,       16};
        vecs[24] = '{1, REMU,   32'd100,      32'd7,        5'd25, 32'd2,        16};
        vecs[25] = '{1, DIV,    32'h8000,     32'hFFFF,     5'd26, 32'h00008000, 0};

        rst_n = 1'b0;
        v32 = 0; f32 = 0; op32 = 0; a32 = 0; b32 = 0; rd32 = 0;
        v16 = 0; f16 = 0; op16 = 0; a16 = 0; b16 = 0; rd16 = 0;
        repeat (2) @(negedge clk);
        chk("reset.ready",  {31'h0, rdy32}, 32'h1);
        chk("reset.stall",  {31'h0, stl32}, 32'h0);
        chk("reset.valid",  {31'h0, vo32},  32'h0);
        chk("reset.result", res32, 32'h0);
        chk("reset.rd",     {27'h0, rdo32}, 32'h0);
        chk("reset.result16", {16'h0, res16}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // Flush at CALC cycle 10: no result, idle next cycle, then a fresh op.
        @(negedge clk);
        drive(0, 1'b1, MUL, 32'd3, 32'd5, 5'd30);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, MUL, 32'd3, 32'd5, 5'd30);
        repeat (9) @(negedge clk);
        chk("flush.stall_before", {31'h0, stl32}, 32'h1);
        f32 = 1'b1;
        @(negedge clk);
        f32 = 1'b0;
        chk("flush.ready", {31'h0, rdy32}, 32'h1);
        chk("flush.valid", {31'h0, vo32},  32'h0);
        chk("flush.stall", {31'h0, stl32}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vo32) pulses++;
        end
        chk("flush.no_pulse", pulses, 0);
        $display("[TB] flush at CALC cycle 10: pulses=%0d", pulses);
        run_op("after_flush", vecs[4]);

        // Back-to-back: MUL then DIV presented during DONE.
        @(negedge clk);
        drive(0, 1'b1, MUL, 32'd3, 32'd5, 5'd5);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, MUL, 32'd3, 32'd5, 5'd5);
        wait_valid(0, k, seen, stall_low);
        chk("b2b.mul_result", res32, 32'd15);
        chk("b2b.mul_rd", {27'h0, rdo32}, 32'd5);
        drive(0, 1'b1, DIV, 32'd100, 32'd7, 5'd9);
        chk("b2b.done_ready", {31'h0, rdy32}, 32'h0);
        @(negedge clk);
        chk("b2b.idle_ready", {31'h0, rdy32}, 32'h1);
        chk("b2b.idle_stall", {31'h0, stl32}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, DIV, 32'd100, 32'd7, 5'd9);
        wait_valid(0, k, seen, stall_low);
        chk("b2b.div_latency", k, 32);
        chk("b2b.div_result", res32, 32'd14);
        chk("b2b.div_rd", {27'h0, rdo32}, 32'd9);
        $display("[TB] back-to-back MUL rd5 then DIV rd9 -> %h rd=%0d", res32, rdo32);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        drive(0, 1'b1, MUL, 32'd3, 32'd5, 5'd7);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, MUL, 32'd3, 32'd5, 5'd7);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst.valid",  {31'h0, vo32},  32'h0);
        chk("arst.result", res32, 32'h0);
        chk("arst.rd",     {27'h0, rdo32}, 32'h0);
        chk("arst.ready",  {31'h0, rdy32}, 32'h1);
        chk("arst.stall",  {31'h0, stl32}, 32'h0);
        $display("[TB] async reset mid-CALC: result=%h ready=%b", res32, rdy32);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("arst.idle_after", {31'h0, rdy32}, 32'h1);
        run_op("after_reset", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
